// File: rtl/pwm_sample_scheduler_if.sv
// Sample-stream port of the PWM sample scheduler.
// The source holds sample_in and sample_valid_in stable until it sees
// sample_ready_out. A beat transfers on each rising clock edge where both are high.
interface pwm_sample_scheduler_if #(
    parameter int SAMPLE_W = 8
);
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid_in;
    logic                sample_ready_out;

    modport master (
        output sample_in,
        output sample_valid_in,
        input  sample_ready_out
    );

    modport slave (
        input  sample_in,
        input  sample_valid_in,
        output sample_ready_out
    );
endinterface

// File: rtl/pwm_sample_scheduler.sv
// Buffers samples, scales them to the PWM period, and issues one duty-cycle
// update per sample slot, always at a PWM period boundary.
module pwm_sample_scheduler #(
    parameter int SAMPLE_W   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_W     = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          en_in,
    input  logic [31:0]                   period_in,
    input  logic [HOLD_W-1:0]             hold_in,
    pwm_sample_scheduler_if.slave         smp,
    output logic [31:0]                   dc_out,
    output logic                          dc_valid_out,
    output logic                          frame_start_out,
    output logic                          underrun_out,
    output logic [$clog2(FIFO_DEPTH):0]   fill_out,
    output logic [1:0]                    state_dbg_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PROD_W = SAMPLE_W + 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         period_reg_q, period_reg_d;
    logic [HOLD_W-1:0]   hold_reg_q, hold_reg_d;
    logic [31:0]         per_cnt_q, per_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [31:0]         dc_q, dc_d;
    logic                dc_valid_q, dc_valid_d;
    logic                underrun_q, underrun_d;
    logic                silence_pend_q, silence_pend_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];

    logic                full;
    logic                empty;
    logic                period_wrap;
    logic                slot_end;
    logic                pop_sched;
    logic                ready;
    logic                push;
    logic                do_pop;
    logic                flush;
    logic [SAMPLE_W-1:0] head;
    logic [PROD_W-1:0]   product;
    logic [31:0]         scaled;

    assign head        = mem_q[rd_ptr_q];
    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign period_wrap = (per_cnt_q == period_reg_q - 32'd1);
    assign slot_end    = (state_q == ST_RUN) && period_wrap &&
                         (hold_cnt_q == hold_reg_q - HOLD_W'(1));
    assign pop_sched   = !empty && ((state_q == ST_PRIME) || slot_end);

    // A full FIFO still accepts on a scheduled pop cycle, so push and pop coincide.
    assign ready = (state_q != ST_IDLE) && (!full || pop_sched);
    assign push  = smp.sample_valid_in && ready;

    assign product = PROD_W'(head) * PROD_W'(period_reg_q);
    assign scaled  = product[SAMPLE_W +: 32];

    always_comb begin
        state_d        = state_q;
        period_reg_d   = period_reg_q;
        hold_reg_d     = hold_reg_q;
        per_cnt_d      = per_cnt_q;
        hold_cnt_d     = hold_cnt_q;
        dc_d           = dc_q;
        dc_valid_d     = 1'b0;
        underrun_d     = 1'b0;
        silence_pend_d = silence_pend_q;
        do_pop         = 1'b0;
        flush          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                per_cnt_d  = '0;
                hold_cnt_d = '0;
                if (silence_pend_q) begin
                    dc_valid_d     = 1'b1;
                    silence_pend_d = 1'b0;
                end
                if (en_in) begin
                    state_d      = ST_PRIME;
                    period_reg_d = (period_in < 32'd2) ? 32'd2 : period_in;
                    hold_reg_d   = (hold_in == '0) ? HOLD_W'(1) : hold_in;
                end
            end
            ST_PRIME: begin
                if (en_in && !empty) begin
                    do_pop     = 1'b1;
                    dc_d       = scaled;
                    dc_valid_d = 1'b1;
                    state_d    = ST_RUN;
                    per_cnt_d  = '0;
                    hold_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (en_in) begin
                    if (period_wrap) begin
                        per_cnt_d = '0;
                        if (slot_end) begin
                            hold_cnt_d = '0;
                            if (!empty) begin
                                do_pop     = 1'b1;
                                dc_d       = scaled;
                                dc_valid_d = 1'b1;
                            end else begin
                                underrun_d = 1'b1;
                            end
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end else begin
                        per_cnt_d = per_cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shutdown silences the PWM; if a strobe just went out, the zero strobe
        // is deferred one cycle so strobes never land back to back.
        if ((state_q != ST_IDLE) && !en_in) begin
            state_d    = ST_IDLE;
            flush      = 1'b1;
            dc_d       = '0;
            per_cnt_d  = '0;
            hold_cnt_d = '0;
            if (dc_valid_q) begin
                silence_pend_d = 1'b1;
            end else begin
                dc_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= ST_IDLE;
            period_reg_q   <= '0;
            hold_reg_q     <= '0;
            per_cnt_q      <= '0;
            hold_cnt_q     <= '0;
            dc_q           <= '0;
            dc_valid_q     <= 1'b0;
            underrun_q     <= 1'b0;
            silence_pend_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            period_reg_q   <= period_reg_d;
            hold_reg_q     <= hold_reg_d;
            per_cnt_q      <= per_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            dc_q           <= dc_d;
            dc_valid_q     <= dc_valid_d;
            underrun_q     <= underrun_d;
            silence_pend_q <= silence_pend_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= smp.sample_in;
        end
    end

    assign smp.sample_ready_out = ready;
    assign dc_out               = dc_q;
    assign dc_valid_out         = dc_valid_q;
    assign underrun_out         = underrun_q;
    assign frame_start_out      = (state_q == ST_RUN) && (per_cnt_q == 32'd0);
    assign fill_out             = count_q;
    assign state_dbg_out        = state_q;

endmodule
